// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: default width and 3-bit opcodes.
package alu_pkg;

   localparam int WIDTH_DEFAULT = 32;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_XOR  = 3'b010,
      OP_OR   = 3'b011,
      OP_AND  = 3'b100,
      OP_EQ   = 3'b101,
      OP_NEQ  = 3'b110,
      OP_PASS = 3'b111
   } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor; subtraction is a + ~b + 1, borrow is the inverted carry.
module alu_addsub #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             carry_or_borrow
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   full_sum;

   assign b_eff    = sub ? ~b : b;
   assign full_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
   assign sum      = full_sum[WIDTH-1:0];
   assign carry_or_borrow = sub ? ~full_sum[WIDTH] : full_sum[WIDTH];

endmodule

// File: rtl/alu32_reg.sv
// Eight-operation ALU with a one-cycle registered result, carry/borrow and zero flags.
module alu32_reg
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] ALU_a,
   input  logic [WIDTH-1:0] ALU_b,
   input  logic [2:0]       CTRL,
   output logic             out_valid,
   output logic [WIDTH-1:0] ALU_c,
   output logic             Cout,
   output logic             zero
);

   logic [WIDTH-1:0] sum;
   logic             carry_or_borrow;
   logic             is_sub;
   logic [WIDTH-1:0] result;
   logic             flag;

   logic [WIDTH-1:0] alu_c_d, alu_c_q;
   logic             cout_d, cout_q;
   logic             zero_d, zero_q;
   logic             out_valid_d, out_valid_q;

   assign is_sub = (CTRL == OP_SUB);

   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a               (ALU_a),
      .b               (ALU_b),
      .sub             (is_sub),
      .sum             (sum),
      .carry_or_borrow (carry_or_borrow)
   );

   always_comb begin
      result = '0;
      flag   = 1'b0;
      case (CTRL)
         OP_ADD, OP_SUB: begin
            result = sum;
            flag   = carry_or_borrow;
         end
         OP_XOR:  result = ALU_a ^ ALU_b;
         OP_OR:   result = ALU_a | ALU_b;
         OP_AND:  result = ALU_a & ALU_b;
         OP_EQ:   result = {{(WIDTH-1){1'b0}}, (ALU_a == ALU_b)};
         OP_NEQ:  result = {{(WIDTH-1){1'b0}}, (ALU_a != ALU_b)};
         OP_PASS: result = ALU_a;
         default: result = '0;
      endcase
   end

   // Without a new operation the previous result and flags are held.
   always_comb begin
      out_valid_d = in_valid;
      alu_c_d     = alu_c_q;
      cout_d      = cout_q;
      zero_d      = zero_q;
      if (in_valid) begin
         alu_c_d = result;
         cout_d  = flag;
         zero_d  = (result == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_c_q     <= '0;
         cout_q      <= 1'b0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         alu_c_q     <= alu_c_d;
         cout_q      <= cout_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign ALU_c     = alu_c_q;
   assign Cout      = cout_q;
   assign zero      = zero_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu32_reg.sv
// Self-checking bench for alu32_reg: directed test-plan steps, then random traffic against a reference model.
module tb_alu32_reg;
   import alu_pkg::*;

   localparam int W = 32;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [W-1:0]  alu_a;
   logic [W-1:0]  alu_b;
   logic [2:0]    ctrl;
   logic          out_valid;
   logic [W-1:0]  alu_c;
   logic          cout;
   logic          zero;

   int pass_count  = 0;
   int check_count = 0;

   // Reference model state: what the registered outputs should show.
   logic          exp_valid;
   logic [W-1:0]  exp_c;
   logic          exp_cout;
   logic          exp_zero;

   alu32_reg #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .ALU_a     (alu_a),
      .ALU_b     (alu_b),
      .CTRL      (ctrl),
      .out_valid (out_valid),
      .ALU_c     (alu_c),
      .Cout      (cout),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: evaluates each operation from its arithmetic definition.
   task automatic modelStep(input logic r, input logic v, input logic [2:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b);
      longint unsigned wide;
      if (r) begin
         exp_valid = 1'b0;
         exp_c     = '0;
         exp_cout  = 1'b0;
         exp_zero  = 1'b0;
      end else if (v) begin
         exp_valid = 1'b1;
         exp_cout  = 1'b0;
         case (op)
            3'd0: begin
               wide     = longint'(a) + longint'(b);
               exp_c    = wide[W-1:0];
               exp_cout = (wide > 64'h0000_0000_FFFF_FFFF);
            end
            3'd1: begin
               exp_c    = a - b;
               exp_cout = (a < b);
            end
            3'd2: exp_c = a ^ b;
            3'd3: exp_c = a | b;
            3'd4: exp_c = a & b;
            3'd5: exp_c = (a == b) ? 32'd1 : 32'd0;
            3'd6: exp_c = (a != b) ? 32'd1 : 32'd0;
            default: exp_c = a;
         endcase
         exp_zero = (exp_c == 0);
      end else begin
         exp_valid = 1'b0;
      end
   endtask

   task automatic checkValue(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      check_count++;
      assert (obs === expv) pass_count++;
      else $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
   endtask

   task automatic checkOutput(input string tag);
      checkValue({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
      checkValue({tag, ".ALU_c"},     alu_c,              exp_c);
      checkValue({tag, ".Cout"},      {31'd0, cout},      {31'd0, exp_cout});
      checkValue({tag, ".zero"},      {31'd0, zero},      {31'd0, exp_zero});
   endtask

   // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic applyStimulus(input string tag, input logic r, input logic v, input logic [2:0] op,
                                input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      rst      = r;
      in_valid = v;
      ctrl     = op;
      alu_a    = a;
      alu_b    = b;
      @(posedge clk);
      #1;
      modelStep(r, v, op, a, b);
      checkOutput(tag);
   endtask

   initial begin
      logic          r_r, v_r;
      logic [2:0]    op_r;
      logic [W-1:0]  a_r, b_r;

      rst      = 1'b1;
      in_valid = 1'b1;
      ctrl     = OP_ADD;
      alu_a    = 32'h1;
      alu_b    = 32'h1;

      $display("[TB] reset sequence");
      applyStimulus("reset0", 1'b1, 1'b1, OP_ADD, 32'h1, 32'h1);
      applyStimulus("reset1", 1'b1, 1'b1, OP_ADD, 32'h1, 32'h1);
      checkValue("reset_zero_low", {31'd0, zero}, 32'd0);
      applyStimulus("idle_after_reset", 1'b0, 1'b0, OP_ADD, 32'h1, 32'h1);
      checkValue("idle_valid_low", {31'd0, out_valid}, 32'd0);

      $display("[TB] add/sub");
      applyStimulus("add_small", 1'b0, 1'b1, OP_ADD, 32'h0000000F, 32'h00000001);
      checkValue("add_small_lit", alu_c, 32'h00000010);
      applyStimulus("sub_small", 1'b0, 1'b1, OP_SUB, 32'h0000000F, 32'h00000001);
      checkValue("sub_small_lit", alu_c, 32'h0000000E);
      applyStimulus("add_wrap", 1'b0, 1'b1, OP_ADD, 32'hFFFFFFFF, 32'h00000001);
      checkValue("add_wrap_lit", {cout, zero, alu_c[29:0]}, {2'b11, 30'd0});
      applyStimulus("sub_borrow", 1'b0, 1'b1, OP_SUB, 32'h00000000, 32'h00000001);
      checkValue("sub_borrow_lit", alu_c, 32'hFFFFFFFF);
      checkValue("sub_borrow_cout", {31'd0, cout}, 32'd1);

      $display("[TB] logic ops");
      applyStimulus("xor", 1'b0, 1'b1, OP_XOR, 32'hA5A5A5A5, 32'h5A5A5A5A);
      checkValue("xor_lit", alu_c, 32'hFFFFFFFF);
      applyStimulus("or",  1'b0, 1'b1, OP_OR,  32'h0000FFFF, 32'hFFFF0000);
      checkValue("or_lit", alu_c, 32'hFFFFFFFF);
      applyStimulus("and", 1'b0, 1'b1, OP_AND, 32'h0000FFFF, 32'hFFFF0000);
      checkValue("and_zero_lit", {31'd0, zero}, 32'd1);

      $display("[TB] compare and pass");
      applyStimulus("eq_true",  1'b0, 1'b1, OP_EQ,  32'h12345678, 32'h12345678);
      checkValue("eq_true_lit", alu_c, 32'h00000001);
      applyStimulus("neq_true", 1'b0, 1'b1, OP_NEQ, 32'h12345678, 32'h87654321);
      checkValue("neq_true_lit", alu_c, 32'h00000001);
      applyStimulus("eq_false", 1'b0, 1'b1, OP_EQ,  32'h12345678, 32'h87654321);
      checkValue("eq_false_zero", {31'd0, zero}, 32'd1);
      applyStimulus("pass", 1'b0, 1'b1, OP_PASS, 32'h0EADBEEF, 32'h00000000);
      checkValue("pass_lit", alu_c, 32'h0EADBEEF);

      $display("[TB] pipeline, hold and mid-stream reset");
      applyStimulus("pipe_add", 1'b0, 1'b1, OP_ADD, 32'h00000003, 32'h00000004);
      applyStimulus("pipe_sub", 1'b0, 1'b1, OP_SUB, 32'h00000010, 32'h00000020);
      applyStimulus("pipe_xor", 1'b0, 1'b1, OP_XOR, 32'hF0F0F0F0, 32'h0FF00FF0);
      applyStimulus("hold", 1'b0, 1'b0, OP_AND, 32'h0, 32'h0);
      checkValue("hold_lit", alu_c, 32'hFF00FF00);
      applyStimulus("mid_reset", 1'b1, 1'b1, OP_PASS, 32'hDEADBEEF, 32'h0);
      applyStimulus("post_reset_idle", 1'b0, 1'b0, OP_PASS, 32'hDEADBEEF, 32'h0);

      $display("[TB] random traffic");
      for (int i = 0; i < 300; i++) begin
         r_r  = ($urandom_range(0, 19) == 0);
         v_r  = ($urandom_range(0, 3) != 0);
         op_r = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0:       a_r = 32'hFFFFFFFF;
            1:       a_r = 32'h0;
            default: a_r = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       b_r = a_r;
            1:       b_r = 32'h1;
            2:       b_r = 32'hFFFFFFFF;
            default: b_r = $urandom;
         endcase
         applyStimulus("random", r_r, v_r, op_r, a_r, b_r);
      end

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
